// File: rtl/tictac_board_engine.sv
// N x N tic-tac-toe engine: edge-detected moves, one-line-per-cycle win scanner,
// alternating starter and saturating per-player / tie score counters.
module tictac_board_engine #(
  parameter int N       = 3,
  parameter int POS_W   = 4,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_W-1:0]   cursorPos,
  input  logic               set,
  input  logic               new_game,
  output logic [2*N*N-1:0]   grid,
  output logic [SCORE_W-1:0] P1WINS,
  output logic [SCORE_W-1:0] P2WINS,
  output logic [SCORE_W-1:0] ties,
  output logic               mode,
  output logic               busy,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               move_err
);

  localparam int CELLS  = N * N;
  localparam int LINES  = 2 * N + 2;
  localparam int LINE_W = $clog2(LINES);
  localparam int MC_W   = $clog2(CELLS + 1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [2*N*N-1:0]    grid_n;
  logic [SCORE_W-1:0]  p1_n, p2_n, ties_n;
  logic                mode_n, starter, starter_n, move_err_n;
  logic [1:0]          winner_n;
  logic [MC_W-1:0]     move_count, move_count_n;
  logic [LINE_W-1:0]   line, line_n;
  logic [1:0]          rst_sync;
  logic                rst_int;
  logic                set_q, set_edge;
  logic                in_range, line_hit;
  logic [POS_W-1:0]    pos_idx;
  logic [1:0]          target, mover;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] c);
    if (c == {SCORE_W{1'b1}}) begin
      return c;
    end else begin
      return c + SCORE_W'(1);
    end
  endfunction

  // Cell index of the i-th cell of scan line k (rows, columns, diagonal, anti-diagonal).
  function automatic int cell_of(input int k, input int i);
    if (k < N) begin
      return k * N + i;
    end else if (k < 2 * N) begin
      return i * N + (k - N);
    end else if (k == 2 * N) begin
      return i * (N + 1);
    end else begin
      return (i + 1) * (N - 1);
    end
  endfunction

  // Reset: asserts asynchronously, releases after two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_int = rst_sync[1];

  assign set_edge = set & ~set_q;
  assign mover    = {mode, ~mode};
  assign in_range = ({1'b0, cursorPos} < (POS_W + 1)'(CELLS));
  assign pos_idx  = in_range ? cursorPos : {POS_W{1'b0}};
  assign target   = grid[2*int'(pos_idx) +: 2];

  // Does the line currently addressed by the scanner belong entirely to the mover?
  always_comb begin
    line_hit = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (grid[2*cell_of(int'(line), i) +: 2] != mover) begin
        line_hit = 1'b0;
      end else begin
        line_hit = line_hit;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    grid_n       = grid;
    mode_n       = mode;
    starter_n    = starter;
    move_count_n = move_count;
    line_n       = line;
    winner_n     = winner;
    move_err_n   = 1'b0;
    p1_n         = P1WINS;
    p2_n         = P2WINS;
    ties_n       = ties;

    if (new_game) begin
      // Aborting a scan leaves scores untouched; a coincident set edge is dropped.
      grid_n       = '0;
      move_count_n = '0;
      line_n       = '0;
      winner_n     = 2'b00;
      state_n      = PLAY;
      starter_n    = ~starter;
      mode_n       = ~starter;
    end else begin
      case (state)
        PLAY: begin
          if (set_edge) begin
            if (!in_range || target != 2'b00) begin
              move_err_n = 1'b1;
            end else begin
              grid_n[2*int'(pos_idx) +: 2] = mover;
              move_count_n = move_count + MC_W'(1);
              line_n       = '0;
              state_n      = CHECK;
            end
          end else begin
            state_n = PLAY;
          end
        end
        CHECK: begin
          if (line_hit) begin
            state_n  = DONE;
            winner_n = mover;
            if (mode) begin
              p2_n = sat_inc(P2WINS);
            end else begin
              p1_n = sat_inc(P1WINS);
            end
          end else if (line == LINE_W'(LINES - 1)) begin
            if (move_count == MC_W'(CELLS)) begin
              state_n  = DONE;
              winner_n = 2'b11;
              ties_n   = sat_inc(ties);
            end else begin
              mode_n  = ~mode;
              state_n = PLAY;
            end
          end else begin
            line_n = line + LINE_W'(1);
          end
        end
        DONE: begin
          state_n = DONE;
        end
        default: begin
          state_n = PLAY;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state      <= PLAY;
      grid       <= '0;
      mode       <= 1'b0;
      starter    <= 1'b0;
      move_count <= '0;
      line       <= '0;
      winner     <= 2'b00;
      move_err   <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      P1WINS     <= '0;
      P2WINS     <= '0;
      ties       <= '0;
      set_q      <= 1'b0;
    end else begin
      state      <= state_n;
      grid       <= grid_n;
      mode       <= mode_n;
      starter    <= starter_n;
      move_count <= move_count_n;
      line       <= line_n;
      winner     <= winner_n;
      move_err   <= move_err_n;
      busy       <= (state_n == CHECK);
      game_over  <= (state_n == DONE);
      P1WINS     <= p1_n;
      P2WINS     <= p2_n;
      ties       <= ties_n;
      set_q      <= set;
    end
  end

endmodule

// File: doc/tictac_board_engine.md
Name: tictac_board_engine

Overview:
- Parametrised successor to the fixed 3x3 game core: an N x N board, N-in-a-row win detection, and saturating per-player and tie score counters.
- Sits between the cursor/button debounce logic and the display/score renderer.
- Moves come from a level `set` input that is edge-detected internally.
- Wins are found by a sequential line scanner (one line per cycle), so logic stays small for any N.
- Adds features the previous core lacks: `new_game` control, move-error flag, busy/game-over/winner status, and alternating starting player.

Parameters:
- N, 3, board side; legal range 3..8; win requires N in a row.
- POS_W, 4, cursorPos width; must satisfy 2^POS_W >= N*N.
- SCORE_W, 8, width of P1WINS/P2WINS/ties; counters saturate at all-ones.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cursorPos  in  POS_W  target cell index = row*N+col.
- set  in  1  move request, level; only the rising edge (set & ~set_q) counts.
- new_game  in  1  clear board, keep scores; honoured in any state.
- grid  out  2*N*N  cell i at bits [2i+1:2i]; 00 empty, 01 P1, 10 P2, 11 never produced.
- P1WINS  out  SCORE_W  P1 win count.
- P2WINS  out  SCORE_W  P2 win count.
- ties  out  SCORE_W  draw count.
- mode  out  1  player to move: 0 = P1, 1 = P2.
- busy  out  1  high while in CHECK.
- game_over  out  1  high while in DONE.
- winner  out  2  01 P1, 10 P2, 11 tie, 00 game in progress.
- move_err  out  1  one-cycle pulse on a rejected move.

Behaviour:
- Reset (rst=0, async):
  - grid=0; all counters=0; mode=0; starter=0; set_q=0.
  - state=PLAY; busy=0; game_over=0; winner=00; move_err=0.
  - Deassertion of rst is synchronised in 2 flops.
- States: PLAY, CHECK, DONE. All outputs are registered.
- PLAY, on a set rising edge:
  - Rejected if cursorPos >= N*N or the target cell != 00. Then move_err=1 for one cycle; grid and mode unchanged; stay in PLAY.
  - Accepted otherwise. Write code {mode,~mode} to the cell, move_count++, line=0, go to CHECK.
- CHECK (one line per cycle):
  - Line order: rows 0..N-1 (indices 0..N-1), cols 0..N-1 (indices N..2N-1), main diagonal 0,N+1,.. (index 2N), anti-diagonal N-1,2N-2,.. (index 2N+1).
  - A line hits when all N of its cells equal the mover's code.
  - On a hit: go to DONE; winner = mover code; the mover's counter increments (saturating).
  - If line 2N+1 misses:
    - move_count==N*N: go to DONE, winner=11, ties++ (saturating).
    - otherwise: mode toggles, return to PLAY.
- Latency: if the accept edge is E0, line k is evaluated at edge E(k+1). Worst case 2N+2 cycles.
- set edges arriving during CHECK or DONE are ignored. set_q keeps tracking, so a set held high across CHECK does not re-fire.
- DONE: holds the grid and winner. game_over=1.
- new_game (any state, including mid-CHECK):
  - Next cycle: grid=0, move_count=0, winner=00, state=PLAY.
  - starter toggles and mode=starter, so the starting player alternates between games.
  - If it aborts a CHECK, no score changes.
  - It has priority over a set edge in the same cycle; that set edge is dropped.
- Counters change only on game completion. Only rst clears them.
- Saturation: a counter at 2^SCORE_W-1 stays there.

Test Plan:
- N=3, moves P1→4, P2→3, P1→1, P2→2, P1→7 (set pulsed 0→1 each) → after the 5th accept, busy for 5 cycles (column line 4 hits at E5); game_over=1, winner=01, P1WINS=1, grid=18'b00_01_00_00_01_10_10_01_00.
- set held high 20 cycles with cursorPos=4 → exactly one move; mode toggles once; no move_err.
- Occupied cell 4 or cursorPos=9 → move_err high 1 cycle; grid and mode unchanged; state PLAY.
- Draw sequence 0,1,2,4,3,5,7,6,8 → after the last move, 8 busy cycles, then winner=11, ties=1; new_game → grid=0, mode=1 (P2 starts).
- SCORE_W=2, P1 wins 4 games (new_game between games) → P1WINS=3 after games 3 and 4.
- rst low during CHECK → all outputs return to their reset values immediately; new_game asserted in CHECK → board clears, scores unchanged.
